// File: rtl/piso_serializer_pkg.sv
// Purpose: shared FSM state encoding and line-level constants for the PISO framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_shifter.sv
// Purpose: DATA_W-bit load/shift register presenting the next payload bit on bit_out.
// Latency: load/shift take effect on the next clk edge; bit_out is combinational from the register.
// Backpressure: none; the owner decides when to load or shift.
// Ports: clk/rst (async active-low), load (d -> register, wins over shift), shift (advance one bit),
//        d (parallel word), bit_out (LSB when MSB_FIRST=0, MSB when MSB_FIRST=1).
module piso_shifter #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              bit_out
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      if (MSB_FIRST) sr <= {sr[DATA_W-2:0], 1'b0};
      else           sr <= {1'b0, sr[DATA_W-1:1]};
    end
  end

  assign bit_out = MSB_FIRST ? sr[DATA_W-1] : sr[0];

endmodule

// File: rtl/piso_serializer.sv
// Purpose: frames DATA_W-bit words as start(0) + data + stop(1) on a registered serial line.
// Latency: start bit appears on sout from the accepting edge; a frame lasts DATA_W+2 cycles.
// Backpressure: din_ready = !hold_full; a one-word hold register keeps frames back-to-back.
// Ports: clk, rst (async active-low), din/din_valid/din_ready (handshake),
//        sout (serial line, idles high), busy (frame on line), frame_done (stop-bit cycle).
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] hold;
  logic              hold_full, hold_full_nxt;
  logic              hold_wr;
  logic              sout_nxt;
  logic              sh_load, sh_shift;
  logic [DATA_W-1:0] sh_d;
  logic              sh_bit;
  logic              fire;

  assign din_ready = !hold_full;
  assign fire      = din_valid && din_ready;

  piso_shifter #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .shift   (sh_shift),
    .d       (sh_d),
    .bit_out (sh_bit)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sout_nxt      = sout;
    sh_load       = 1'b0;
    sh_shift      = 1'b0;
    sh_d          = din;
    hold_wr       = 1'b0;
    hold_full_nxt = hold_full;
    case (state)
      ST_IDLE: begin
        sout_nxt = LINE_IDLE;
        cnt_nxt  = '0;
        if (fire) begin
          sh_load   = 1'b1;
          sout_nxt  = START_BIT;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        // Emit bit 0 and shift at once so the next bit is already on bit_out.
        hold_wr   = fire;
        sh_shift  = 1'b1;
        sout_nxt  = sh_bit;
        cnt_nxt   = '0;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        hold_wr = fire;
        if (cnt == LAST_BIT) begin
          sout_nxt  = STOP_BIT;
          state_nxt = ST_STOP;
        end else begin
          sh_shift = 1'b1;
          sout_nxt = sh_bit;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        // A held word always wins; din_ready is low then, so no new word can collide.
        if (hold_full) begin
          sh_load       = 1'b1;
          sh_d          = hold;
          hold_full_nxt = 1'b0;
          sout_nxt      = START_BIT;
          state_nxt     = ST_START;
        end else if (fire) begin
          sh_load   = 1'b1;
          sout_nxt  = START_BIT;
          state_nxt = ST_START;
        end else begin
          sout_nxt  = LINE_IDLE;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        sout_nxt  = LINE_IDLE;
        state_nxt = ST_IDLE;
      end
    endcase
    if (hold_wr) hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sout       <= LINE_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      hold_full  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sout       <= sout_nxt;
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= (state_nxt == ST_STOP);
      hold_full  <= hold_full_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         hold <= '0;
    else if (hold_wr) hold <= din;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Purpose: self-checking bench for piso_serializer, LSB-first and MSB-first instances side by side.
// Latency: n/a.
// Backpressure: driver honours din_ready for multi-word bursts.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         rdy0, sout0, busy0, fd0;
  logic         rdy1, sout1, busy1, fd1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .sout(sout0), .busy(busy0), .frame_done(fd0)
  );

  piso_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .sout(sout1), .busy(busy1), .frame_done(fd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: current word and its position in the frame
  // (0 = start bit, 1..W = data bits, W+1 = stop bit), plus a one-deep hold queue.
  logic [W-1:0] m_word = '0;
  int           m_pos  = 0;
  bit           m_active = 1'b0;
  logic [W-1:0] hold_q[$];
  logic [W-1:0] exp_words[$];

  always @(posedge clk) begin
    bit m_fire;
    if (!rst) begin
      m_active = 1'b0;
      m_pos    = 0;
      hold_q.delete();
      exp_words.delete();
    end else begin
      m_fire = din_valid && (hold_q.size() == 0);
      if (m_fire) exp_words.push_back(din);
      if (m_active && m_pos < W + 1) begin
        if (m_fire) hold_q.push_back(din);
        m_pos++;
      end else if (hold_q.size() != 0) begin
        m_word   = hold_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_fire) begin
        m_word   = din;
        m_active = 1'b1;
        m_pos    = 0;
      end else begin
        m_active = 1'b0;
      end
    end
  end

  function automatic logic exp_sout(input bit msb);
    if (!m_active)      return 1'b1;
    if (m_pos == 0)     return 1'b0;
    if (m_pos == W + 1) return 1'b1;
    return msb ? m_word[W - m_pos] : m_word[m_pos - 1];
  endfunction

  // Per-cycle compare plus a receiver that decodes the LSB-first line into words.
  int           rx_n = 0;
  int           rx_frames = 0;
  logic [W-1:0] rx_word = '0;

  always @(posedge clk) begin
    logic [W-1:0] w;
    #1;
    chk("sout_lsb",   {31'd0, sout0}, {31'd0, exp_sout(1'b0)});
    chk("sout_msb",   {31'd0, sout1}, {31'd0, exp_sout(1'b1)});
    chk("busy_lsb",   {31'd0, busy0}, {31'd0, m_active});
    chk("busy_msb",   {31'd0, busy1}, {31'd0, m_active});
    chk("done_lsb",   {31'd0, fd0},   {31'd0, (m_active && m_pos == W + 1)});
    chk("done_msb",   {31'd0, fd1},   {31'd0, (m_active && m_pos == W + 1)});
    chk("ready_lsb",  {31'd0, rdy0},  {31'd0, (hold_q.size() == 0)});
    chk("ready_msb",  {31'd0, rdy1},  {31'd0, (hold_q.size() == 0)});
    if (!rst || !busy0) begin
      rx_n = 0;
    end else begin
      if (rx_n >= 1 && rx_n <= W) rx_word[rx_n - 1] = sout0;
      rx_n++;
      if (fd0) begin
        rx_frames++;
        rx_n = 0;
        total++;
        if (exp_words.size() == 0) begin
          bad++;
          $display("FAIL rx_order: got frame %h, expected no frame", rx_word);
        end else begin
          w = exp_words.pop_front();
          if (rx_word !== w) begin
            bad++;
            $display("FAIL rx_order: got %h, expected %h", rx_word, w);
          end
        end
      end
    end
  end

  logic [15:0] cap0, cap1;

  task automatic cap_one();
    @(posedge clk);
    #1;
    cap0 = {cap0[14:0], sout0};
    cap1 = {cap1[14:0], sout1};
  endtask

  task automatic cap_n(input int n);
    for (int i = 0; i < n; i++) cap_one();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy0 && n < 300);
    chk("idle_timeout", {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] words[3];
    int idx, stall, guard, frames0;

    // 1: async reset takes effect without a clock edge
    #3 rst = 1'b0;
    #1;
    chk("rst_sout",  {31'd0, sout0}, 32'd1);
    chk("rst_busy",  {31'd0, busy0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0},  32'd1);
    chk("rst_done",  {31'd0, fd0},   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 2: single word from idle
    cap0 = '0; cap1 = '0;
    din = 4'b1010; din_valid = 1'b1;
    cap_one();
    @(negedge clk); din_valid = 1'b0;
    cap_n(6);
    chk("t2_lsb", {16'd0, cap0}, 32'b0010111);
    chk("t2_msb", {16'd0, cap1}, 32'b0101011);

    // 3: back-to-back F then 0, second word goes through the hold register
    @(negedge clk);
    cap0 = '0; cap1 = '0;
    din = 4'hF; din_valid = 1'b1;
    cap_one();
    @(negedge clk); din = 4'h0;
    cap_one();
    chk("t3_ready_low", {31'd0, rdy0}, 32'd0);
    @(negedge clk); din_valid = 1'b0;
    cap_n(11);
    chk("t3_lsb", {16'd0, cap0}, 32'b0111110000011);
    chk("t3_msb", {16'd0, cap1}, 32'b0111110000011);

    // 4: three words with valid held high; third stalls until the first frame's stop edge
    words[0] = 4'h3; words[1] = 4'hC; words[2] = 4'h9;
    frames0 = rx_frames;
    @(negedge clk);
    idx = 0; stall = 0; guard = 0;
    din_valid = 1'b1;
    while (idx < 3 && guard < 100) begin
      din = words[idx];
      if (rdy0) idx++;
      else      stall++;
      @(negedge clk);
      guard++;
    end
    din_valid = 1'b0;
    chk("t4_accepted", idx, 32'd3);
    chk("t4_stall", stall, 32'd5);
    wait_idle();
    chk("t4_frames", rx_frames - frames0, 32'd3);
    chk("t4_pending", exp_words.size(), 32'd0);

    // 5: reset mid-frame with a word held, then a clean frame
    @(negedge clk);
    din = 4'hA; din_valid = 1'b1;
    @(negedge clk); din = 4'h6;
    @(negedge clk); din_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t5_sout",  {31'd0, sout0}, 32'd1);
    chk("t5_busy",  {31'd0, busy0}, 32'd0);
    chk("t5_ready", {31'd0, rdy0},  32'd1);
    chk("t5_done",  {31'd0, fd0},   32'd0);
    chk("t5_busy_msb", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    cap0 = '0; cap1 = '0;
    din = 4'h5; din_valid = 1'b1;
    cap_one();
    @(negedge clk); din_valid = 1'b0;
    cap_n(6);
    chk("t5_lsb", {16'd0, cap0}, 32'b0101011);
    chk("t5_msb", {16'd0, cap1}, 32'b0010111);

    // 6: bit order of 4'b1000
    @(negedge clk);
    cap0 = '0; cap1 = '0;
    din = 4'b1000; din_valid = 1'b1;
    cap_one();
    @(negedge clk); din_valid = 1'b0;
    cap_n(6);
    chk("t6_msb", {16'd0, cap1}, 32'b0100011);
    chk("t6_lsb", {16'd0, cap0}, 32'b0000111);

    // 7: word offered during the stop cycle with hold empty loads directly, no gap
    @(negedge clk);
    cap0 = '0; cap1 = '0;
    din = 4'h1; din_valid = 1'b1;
    cap_one();
    @(negedge clk); din_valid = 1'b0;
    cap_n(5);
    @(negedge clk); din = 4'hE; din_valid = 1'b1;
    cap_one();
    @(negedge clk); din_valid = 1'b0;
    cap_n(6);
    chk("t7_lsb", {16'd0, cap0}, 32'b0100010011111);
    chk("t7_msb", {16'd0, cap1}, 32'b0000110111011);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
